// File: rtl/arithmetic_left_shift_sequential_saturating_if.sv
// arithmetic_left_shift_sequential_saturating_if: operand/result handshake bundle for the saturating left shifter
interface arithmetic_left_shift_sequential_saturating_if #(
  parameter int N  = 8,
  parameter int SW = 3
);
  logic          in_valid;
  logic          in_ready;
  logic [N-1:0]  a;
  logic [SW-1:0] s;
  logic          out_valid;
  logic          out_ready;
  logic [N-1:0]  res;
  logic          ovf;
  modport master (
    output in_valid, a, s, out_ready,
    input  in_ready, out_valid, res, ovf
  );
  modport slave (
    input  in_valid, a, s, out_ready,
    output in_ready, out_valid, res, ovf
  );
endinterface

// File: rtl/arithmetic_left_shift_sequential_saturating.sv
// arithmetic_left_shift_sequential_saturating: signed a*2^s, one shift per clock, saturating on overflow
module arithmetic_left_shift_sequential_saturating #(
  parameter int N  = 8,
  parameter int SW = 3
) (
  input logic clk,
  input logic rst_n,
  arithmetic_left_shift_sequential_saturating_if.slave bus
);
  typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;
  state_t        r_state, w_next;
  logic [N-1:0]  r_acc;
  logic [SW-1:0] r_cnt;
  logic          r_sign, r_ovf;
  logic          w_load;
  assign w_load = bus.in_valid && r_state == IDLE;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= IDLE;
      r_acc   <= '0;
      r_cnt   <= '0;
      r_sign  <= 1'b0;
      r_ovf   <= 1'b0;
    end else begin
      r_state <= w_next;
      if (w_load) begin
        r_acc  <= bus.a;
        r_cnt  <= bus.s;
        r_sign <= bus.a[N-1];
        r_ovf  <= 1'b0;
      end else if (r_state == SHIFT) begin
        // a sign change on any step means the true product left the range
        if (r_acc[N-1] != r_acc[N-2]) r_ovf <= 1'b1;
        r_acc <= {r_acc[N-2:0], 1'b0};
        r_cnt <= r_cnt - SW'(1);
      end
    end
  end
  always_comb begin
    w_next = r_state;
    if (w_load) w_next = (bus.s == '0) ? DONE : SHIFT;
    else if (r_state == SHIFT && r_cnt == SW'(1)) w_next = DONE;
    else if (r_state == DONE && bus.out_ready) w_next = IDLE;
  end
  assign bus.in_ready  = r_state == IDLE;
  assign bus.out_valid = r_state == DONE;
  assign bus.ovf       = r_ovf;
  assign bus.res       = r_ovf ? {r_sign, {(N-1){~r_sign}}} : r_acc;
endmodule

// File: tb/tb_arithmetic_left_shift_sequential_saturating.sv
// tb_arithmetic_left_shift_sequential_saturating: directed and exhaustive checks of the saturating shifter
module tb_arithmetic_left_shift_sequential_saturating;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int checks = 0;
  int errors = 0;
  arithmetic_left_shift_sequential_saturating_if #(.N(8), .SW(3)) bus ();
  arithmetic_left_shift_sequential_saturating #(.N(8), .SW(3)) dut (
    .clk(clk),
    .rst_n(rst_n),
    .bus(bus)
  );
  always #5 clk = ~clk;
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask
  task automatic run_op(input string tag, input logic [7:0] av, input logic [2:0] sv,
                        input logic [7:0] er, input logic eo);
    int lat;
    @(negedge clk);
    chk({tag, "_in_ready"}, 32'(bus.in_ready), 32'd1);
    bus.in_valid = 1'b1;
    bus.a = av;
    bus.s = sv;
    bus.out_ready = 1'b1;
    @(negedge clk);
    bus.in_valid = 1'b0;
    bus.a = 8'hA5;
    bus.s = 3'd5;
    lat = 1;
    while (!bus.out_valid && lat < 40) begin
      @(negedge clk);
      lat++;
    end
    chk({tag, "_latency"}, 32'(lat), 32'(sv) + 32'd1);
    chk({tag, "_res"}, 32'(bus.res), 32'(er));
    chk({tag, "_ovf"}, 32'(bus.ovf), 32'(eo));
    @(negedge clk);
    chk({tag, "_back_idle"}, {30'd0, bus.in_ready, bus.out_valid}, 32'b10);
  endtask
  initial begin
    int p, er;
    logic [7:0] av;
    bus.in_valid = 1'b0;
    bus.a = '0;
    bus.s = '0;
    bus.out_ready = 1'b0;
    #12;
    chk("rst_in_ready", 32'(bus.in_ready), 32'd1);
    chk("rst_out_valid", 32'(bus.out_valid), 32'd0);
    chk("rst_res", 32'(bus.res), 32'd0);
    chk("rst_ovf", 32'(bus.ovf), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    run_op("pos", 8'd5, 3'd3, 8'h28, 1'b0);
    run_op("neg", 8'hFD, 3'd2, 8'hF4, 1'b0);
    run_op("sat_pos", 8'd20, 3'd3, 8'h7F, 1'b1);
    run_op("sat_neg", 8'hEC, 3'd3, 8'h80, 1'b1);
    run_op("exact_min", 8'hC0, 3'd1, 8'h80, 1'b0);
    run_op("pass", 8'h9C, 3'd0, 8'h9C, 1'b0);
    run_op("zero", 8'd0, 3'd7, 8'h00, 1'b0);
    run_op("one_s7", 8'd1, 3'd7, 8'h7F, 1'b1);
    // back-pressure: result held, new request ignored while stalled
    @(negedge clk);
    bus.in_valid = 1'b1;
    bus.a = 8'd5;
    bus.s = 3'd3;
    bus.out_ready = 1'b0;
    @(negedge clk);
    bus.in_valid = 1'b0;
    repeat (3) @(negedge clk);
    chk("bp_valid_cycle4", 32'(bus.out_valid), 32'd1);
    bus.in_valid = 1'b1;
    bus.a = 8'h11;
    bus.s = 3'd0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("bp_res", 32'(bus.res), 32'h28);
      chk("bp_ovf", 32'(bus.ovf), 32'd0);
      chk("bp_in_ready", 32'(bus.in_ready), 32'd0);
      chk("bp_out_valid", 32'(bus.out_valid), 32'd1);
    end
    bus.in_valid = 1'b0;
    bus.out_ready = 1'b1;
    @(negedge clk);
    chk("bp_release", {30'd0, bus.in_ready, bus.out_valid}, 32'b10);
    // asynchronous reset partway through a long shift
    @(negedge clk);
    bus.in_valid = 1'b1;
    bus.a = 8'd3;
    bus.s = 3'd6;
    @(negedge clk);
    bus.in_valid = 1'b0;
    @(negedge clk);
    chk("mid_busy", 32'(bus.in_ready), 32'd0);
    #2 rst_n = 1'b0;
    #1;
    chk("mid_rst_in_ready", 32'(bus.in_ready), 32'd1);
    chk("mid_rst_out_valid", 32'(bus.out_valid), 32'd0);
    chk("mid_rst_res", 32'(bus.res), 32'd0);
    chk("mid_rst_ovf", 32'(bus.ovf), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    run_op("after_rst", 8'd3, 3'd1, 8'd6, 1'b0);
    for (int ai = 0; ai < 256; ai++) begin
      for (int si = 0; si < 8; si++) begin
        av = ai[7:0];
        p = int'($signed(av)) * (1 << si);
        er = (p > 127) ? 127 : (p < -128) ? -128 : p;
        run_op("sweep", av, si[2:0], er[7:0], (p > 127) || (p < -128));
      end
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
